indirect_csr_bridge: RTL and testbench
======================================

Name: indirect_csr_bridge

Overview:
Parametrised indirect CSR bridge. It accepts the four-phase indirect CSR command interface (level cmd/addr/writedata, ack held until cmd returns to NOOP) and routes each access to one of NUM_CH downstream pulse-handshake register targets. Compared with the single-target CSR endpoint it adds:
- address-based channel decode;
- a per-access timeout;
- decode and timeout error responses;
- a saturating error counter.

It sits between the host-side indirect CSR master and a bank of feature CSR blocks.

Parameters:
CMD_W, 16, width of i_csr_cmd; only bits [1:0] are decoded, upper bits are reserved and ignored
AW, 19, upstream address width
DW, 64, data width
NUM_CH, 4, number of downstream channels (1..16)
CH_SEL_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel-select width; selects from i_csr_addr[AW-1 -: CH_SEL_W]
CH_AW, AW-CH_SEL_W, downstream local address width
TIMEOUT_CYC, 1024, cycles to wait for a downstream ack before a timeout error

Ports:
i_csr_clk  in  1  single clock
i_csr_rst_n  in  1  reset; asynchronous assert, active-low
i_csr_cmd  in  CMD_W  0=NOOP, 1=READ, 2=WRITE, 3=invalid
i_csr_addr  in  AW  access address
i_csr_writedata  in  DW  write data
o_csr_readdata  out  DW  read data, valid while o_csr_ack=1
o_csr_ack  out  1  access complete; held until cmd==NOOP is sampled
o_csr_rresp  out  2  read response: 0 OKAY, 2 SLVERR, 3 DECERR
o_csr_bresp  out  2  write response, same encoding
o_ch_read  out  NUM_CH  one-hot one-cycle read request pulse
o_ch_write  out  NUM_CH  one-hot one-cycle write request pulse
o_ch_addr  out  CH_AW  local address, shared by all channels
o_ch_writedata  out  DW  shared write data
i_ch_readdata  in  NUM_CH*DW  per-channel read data; channel c occupies [c*DW +: DW]
i_ch_ack  in  NUM_CH  per-channel completion pulse
i_ch_err  in  NUM_CH  per-channel error, qualified by i_ch_ack
o_busy  out  1  high in any state other than IDLE
o_err_count  out  8  saturating count of non-OKAY completions

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, o_err_count 0. Asserting reset mid-access aborts it silently; an i_ch_ack arriving after reset is ignored.
- State IDLE:
  - If cmd[1:0]!=0 is sampled at edge N: latch cmd, addr and writedata; decode ch = addr[AW-1 -: CH_SEL_W].
  - If cmd==3: go to DONE with rresp=bresp=SLVERR.
  - Else if ch>=NUM_CH: go to DONE with rresp=bresp=DECERR; no downstream pulse is issued.
  - Else: go to ISSUE.
- State ISSUE (cycle N+1):
  - Assert o_ch_read[ch] or o_ch_write[ch] for exactly 1 cycle.
  - o_ch_addr and o_ch_writedata are held at the latched values from ISSUE until the response is captured.
  - Go to WAIT with the timeout counter cleared.
- State WAIT:
  - Only i_ch_ack[ch] is honoured. Acks on other channels, or acks outside WAIT, are ignored.
  - On ack: capture readdata = i_ch_readdata[ch] for reads, else 0. Response = SLVERR if i_ch_err[ch], else OKAY. Go to DONE.
  - If the counter reaches TIMEOUT_CYC-1 without an ack: response = SLVERR, readdata = all-ones, go to DONE. A late ack from the timed-out target is ignored.
- State DONE:
  - o_csr_ack=1 from the first DONE cycle. readdata and resp are registered and stable throughout.
  - The response of the operation not performed is 0 (a read sets bresp=0; a write sets rresp=0).
  - When i_csr_cmd[1:0]==0 is sampled: o_csr_ack=0 on the next cycle, return to IDLE.
  - o_err_count increments once on DONE entry for any non-OKAY response and saturates at 255.
- Minimum latency: cmd sampled at N, request pulse at N+1, target ack at earliest N+2, o_csr_ack at N+3. A decode error or invalid command gives o_csr_ack at N+1.
- Command changes while busy (non-NOOP to another non-NOOP) are ignored; the latched access completes.
- A new command is accepted only after cmd==NOOP has been sampled in DONE, so back-to-back accesses need at least one NOOP cycle between them.

Decomposition:
- indirect_csr_pkg holds:
  - CMD_NOOP/CMD_READ/CMD_WRITE constants;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - state enum {IDLE, ISSUE, WAIT, DONE}.
- No sub-module. The timeout counter and error counter are inline and sized $clog2(TIMEOUT_CYC+1) and 8 bits.

Test Plan:
1. NUM_CH=4: write 64'h1111_2222_3333_4444 to 19'h2_0010 -> single o_ch_write=4'b0010 pulse, o_ch_addr=17'h0_0010; target acks 3 cycles later -> o_csr_ack=1, bresp=0; cmd set to NOOP -> ack drops next cycle.
2. Read 19'h2_0010 with channel 1 returning 64'h1111_2222_3333_4444 -> readdata matches, rresp=0; a simultaneous stray i_ch_ack[2] is ignored.
3. NUM_CH=3 instance: read 19'h6_0000 (ch=3) -> no pulse, ack one cycle after sampling, rresp=2'b11, o_err_count=1.
4. TIMEOUT_CYC=16, target never acks -> ack after 16 WAIT cycles, rresp=2'b10, readdata=all-ones; a late ack on the next read is ignored.
5. Target acks with i_ch_err=1 on a write -> bresp=2'b10. Cmd=3 -> SLVERR, no pulse. Force 300 errors -> o_err_count=255.
6. Assert reset during WAIT -> outputs 0 immediately, state IDLE; a post-reset ack causes no o_csr_ack; the next normal read completes OKAY.

Source files
------------

// File: rtl/indirect_csr_pkg.sv
// Shared command, response and state encodings for the indirect CSR bridge.
package indirect_csr_pkg;

  localparam logic [1:0] CMD_NOOP    = 2'd0;
  localparam logic [1:0] CMD_READ    = 2'd1;
  localparam logic [1:0] CMD_WRITE   = 2'd2;
  localparam logic [1:0] CMD_INVALID = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

endpackage

// File: rtl/indirect_csr_bridge.sv
// Four-phase indirect CSR slave fanning out to NUM_CH pulse-handshake targets,
// with channel decode, per-access timeout and a saturating error counter.
module indirect_csr_bridge
  import indirect_csr_pkg::*;
#(
  parameter int CMD_W       = 16,
  parameter int AW          = 19,
  parameter int DW          = 64,
  parameter int NUM_CH      = 4,
  parameter int CH_SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CH_AW       = AW - CH_SEL_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 i_csr_clk,
  input  logic                 i_csr_rst_n,
  input  logic [CMD_W-1:0]     i_csr_cmd,
  input  logic [AW-1:0]        i_csr_addr,
  input  logic [DW-1:0]        i_csr_writedata,
  output logic [DW-1:0]        o_csr_readdata,
  output logic                 o_csr_ack,
  output logic [1:0]           o_csr_rresp,
  output logic [1:0]           o_csr_bresp,
  output logic [NUM_CH-1:0]    o_ch_read,
  output logic [NUM_CH-1:0]    o_ch_write,
  output logic [CH_AW-1:0]     o_ch_addr,
  output logic [DW-1:0]        o_ch_writedata,
  input  logic [NUM_CH*DW-1:0] i_ch_readdata,
  input  logic [NUM_CH-1:0]    i_ch_ack,
  input  logic [NUM_CH-1:0]    i_ch_err,
  output logic                 o_busy,
  output logic [7:0]           o_err_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e              state;
  logic                is_write;
  logic [CH_SEL_W-1:0] ch;
  logic [TW-1:0]       tmo_cnt;

  logic [1:0]          cmd_op;
  logic [CH_SEL_W-1:0] ch_dec;
  logic                dec_err;
  logic                unused_cmd;

  // Completion of the current access this cycle, with its response and data.
  logic                fin;
  logic [1:0]          fin_resp;
  logic [DW-1:0]       fin_rdata;

  assign cmd_op     = i_csr_cmd[1:0];
  assign unused_cmd = ^i_csr_cmd;
  assign ch_dec     = i_csr_addr[AW-1 -: CH_SEL_W];
  assign dec_err    = 32'(ch_dec) >= 32'(NUM_CH);
  assign o_busy     = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    fin       = 1'b0;
    fin_resp  = RESP_OKAY;
    fin_rdata = '0;
    case (state)
      IDLE: begin
        if (cmd_op == CMD_INVALID) begin
          fin      = 1'b1;
          fin_resp = RESP_SLVERR;
        end else if (cmd_op != CMD_NOOP && dec_err) begin
          fin      = 1'b1;
          fin_resp = RESP_DECERR;
        end
      end
      WAIT: begin
        if (i_ch_ack[ch]) begin
          fin      = 1'b1;
          fin_resp = i_ch_err[ch] ? RESP_SLVERR : RESP_OKAY;
          if (!is_write) fin_rdata = i_ch_readdata[ch*DW +: DW];
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          fin      = 1'b1;
          fin_resp = RESP_SLVERR;
          if (!is_write) fin_rdata = '1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_csr_clk or negedge i_csr_rst_n) begin
    if (!i_csr_rst_n) begin
      state          <= IDLE;
      is_write       <= 1'b0;
      ch             <= '0;
      tmo_cnt        <= '0;
      o_csr_ack      <= 1'b0;
      o_csr_readdata <= '0;
      o_csr_rresp    <= RESP_OKAY;
      o_csr_bresp    <= RESP_OKAY;
      o_ch_read      <= '0;
      o_ch_write     <= '0;
      o_ch_addr      <= '0;
      o_ch_writedata <= '0;
    end else begin
      o_ch_read  <= '0;
      o_ch_write <= '0;
      case (state)
        IDLE: begin
          if (cmd_op != CMD_NOOP) begin
            is_write       <= (cmd_op == CMD_WRITE);
            ch             <= ch_dec;
            o_ch_addr      <= i_csr_addr[CH_AW-1:0];
            o_ch_writedata <= i_csr_writedata;
            if (fin) begin
              state          <= DONE;
              o_csr_ack      <= 1'b1;
              o_csr_readdata <= '0;
              o_csr_rresp    <= fin_resp;
              o_csr_bresp    <= fin_resp;
            end else begin
              state <= ISSUE;
              if (cmd_op == CMD_WRITE) o_ch_write <= NUM_CH'(1) << ch_dec;
              else                     o_ch_read  <= NUM_CH'(1) << ch_dec;
            end
          end
        end
        ISSUE: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT: begin
          if (fin) begin
            state          <= DONE;
            o_csr_ack      <= 1'b1;
            o_csr_readdata <= fin_rdata;
            o_csr_rresp    <= is_write ? RESP_OKAY : fin_resp;
            o_csr_bresp    <= is_write ? fin_resp  : RESP_OKAY;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          if (cmd_op == CMD_NOOP) begin
            state          <= IDLE;
            o_csr_ack      <= 1'b0;
            o_csr_readdata <= '0;
            o_csr_rresp    <= RESP_OKAY;
            o_csr_bresp    <= RESP_OKAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_csr_clk or negedge i_csr_rst_n) begin
    if (!i_csr_rst_n) begin
      o_err_count <= '0;
    end else if (fin && fin_resp != RESP_OKAY && o_err_count != 8'hFF) begin
      o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_indirect_csr_bridge.sv
// Scoreboard bench: a 4-channel bridge with a short timeout and a 3-channel
// bridge for decode errors; the bench plays the role of every target.
module tb_indirect_csr_bridge;
  import indirect_csr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Four-channel instance, TIMEOUT_CYC=16
  logic [15:0]  cmd_a;
  logic [18:0]  addr_a;
  logic [63:0]  wdata_a, rdata_a, chwd_a;
  logic         ack_a, busy_a;
  logic [1:0]   rresp_a, bresp_a;
  logic [3:0]   chrd_a, chwr_a, chack_a, cherr_a;
  logic [16:0]  chaddr_a;
  logic [255:0] chrdata_a;
  logic [7:0]   errc_a;

  // Three-channel instance
  logic [15:0]  cmd_b;
  logic [18:0]  addr_b;
  logic [63:0]  wdata_b, rdata_b, chwd_b;
  logic         ack_b, busy_b;
  logic [1:0]   rresp_b, bresp_b;
  logic [2:0]   chrd_b, chwr_b, chack_b, cherr_b;
  logic [16:0]  chaddr_b;
  logic [191:0] chrdata_b;
  logic [7:0]   errc_b;

  indirect_csr_bridge #(.NUM_CH(4), .TIMEOUT_CYC(16)) dut_a (
    .i_csr_clk(clk), .i_csr_rst_n(rst_n), .i_csr_cmd(cmd_a), .i_csr_addr(addr_a),
    .i_csr_writedata(wdata_a), .o_csr_readdata(rdata_a), .o_csr_ack(ack_a),
    .o_csr_rresp(rresp_a), .o_csr_bresp(bresp_a), .o_ch_read(chrd_a), .o_ch_write(chwr_a),
    .o_ch_addr(chaddr_a), .o_ch_writedata(chwd_a), .i_ch_readdata(chrdata_a),
    .i_ch_ack(chack_a), .i_ch_err(cherr_a), .o_busy(busy_a), .o_err_count(errc_a)
  );

  indirect_csr_bridge #(.NUM_CH(3)) dut_b (
    .i_csr_clk(clk), .i_csr_rst_n(rst_n), .i_csr_cmd(cmd_b), .i_csr_addr(addr_b),
    .i_csr_writedata(wdata_b), .o_csr_readdata(rdata_b), .o_csr_ack(ack_b),
    .o_csr_rresp(rresp_b), .o_csr_bresp(bresp_b), .o_ch_read(chrd_b), .o_ch_write(chwr_b),
    .o_ch_addr(chaddr_b), .o_ch_writedata(chwd_b), .i_ch_readdata(chrdata_b),
    .i_ch_ack(chack_b), .i_ch_err(cherr_b), .o_busy(busy_b), .o_err_count(errc_b)
  );

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] rd, input logic [1:0] rr, input logic [1:0] br);
    exp_t e;
    e.rdata = rd;
    e.rresp = rr;
    e.bresp = br;
    exp_q.push_back(e);
    if ((rr | br) != 2'b00 && exp_err < 255) exp_err++;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sbq"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rdata_a, e.rdata);
      check({tag, "_rresp"}, 64'(rresp_a), 64'(e.rresp));
      check({tag, "_bresp"}, 64'(bresp_a), 64'(e.bresp));
      check({tag, "_errc"}, 64'(errc_a), 64'(exp_err));
    end
  endtask

  task automatic finish_access(input string tag);
    pop_check(tag);
    cmd_a = 16'd0;
    tick();
    check({tag, "_ack_drop"}, 64'(ack_a), 64'd0);
    check({tag, "_busy_drop"}, 64'(busy_a), 64'd0);
  endtask

  // lat < 0 means the target never acks; stray adds a same-cycle ack with error on channel 2.
  task automatic access(input string tag, input logic wr, input logic [18:0] a,
                        input logic [63:0] wd, input int lat, input logic err,
                        input logic [63:0] rd, input logic stray);
    int n;
    int c;
    c = int'(a[18:17]);
    if (lat < 0)
      push(wr ? 64'd0 : '1, wr ? RESP_OKAY : RESP_SLVERR, wr ? RESP_SLVERR : RESP_OKAY);
    else
      push(wr ? 64'd0 : rd, wr ? RESP_OKAY : (err ? RESP_SLVERR : RESP_OKAY),
           wr ? (err ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY);
    cmd_a   = wr ? 16'd2 : 16'd1;
    addr_a  = a;
    wdata_a = wd;
    n = 0;
    do begin
      tick();
      n++;
    end while ((chrd_a | chwr_a) == 4'd0 && n < 8);
    check({tag, "_pulse_lat"}, 64'(n), 64'd1);
    check({tag, "_pulse"}, 64'(wr ? chwr_a : chrd_a), 64'(4'b0001 << c));
    check({tag, "_pulse_other"}, 64'(wr ? chrd_a : chwr_a), 64'd0);
    check({tag, "_chaddr"}, 64'(chaddr_a), 64'(a[16:0]));
    if (wr) begin
      check({tag, "_chwdata"}, chwd_a, wd);
      cmd_a = 16'd1;
    end
    tick();
    check({tag, "_pulse_len"}, 64'(chrd_a | chwr_a), 64'd0);
    n = 1;
    if (lat >= 0) begin
      repeat (lat - 1) tick();
      chack_a[c] = 1'b1;
      cherr_a[c] = err;
      chrdata_a[c*64 +: 64] = rd;
      if (stray) begin
        chack_a[2] = 1'b1;
        cherr_a[2] = 1'b1;
        chrdata_a[128 +: 64] = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      tick();
      chack_a = '0;
      cherr_a = '0;
      check({tag, "_ack"}, 64'(ack_a), 64'd1);
    end else begin
      while (!ack_a && n < 40) begin
        tick();
        n++;
      end
      check({tag, "_tmo_lat"}, 64'(n), 64'd17);
    end
    finish_access(tag);
  endtask

  task automatic invalid_cmd(input string tag);
    push(64'd0, RESP_SLVERR, RESP_SLVERR);
    cmd_a  = 16'h8003;
    addr_a = 19'h2_0000;
    tick();
    check({tag, "_ack"}, 64'(ack_a), 64'd1);
    check({tag, "_nopulse"}, 64'(chrd_a | chwr_a), 64'd0);
    finish_access(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_a = '0; addr_a = '0; wdata_a = '0; chack_a = '0; cherr_a = '0; chrdata_a = '0;
    cmd_b = '0; addr_b = '0; wdata_b = '0; chack_b = '0; cherr_b = '0; chrdata_b = '0;
    repeat (2) tick();
    check("rst_ack", 64'(ack_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_pulses", 64'(chrd_a | chwr_a), 64'd0);
    check("rst_errc", 64'(errc_a), 64'd0);
    check("rst_rdata", rdata_a, 64'd0);
    rst_n = 1'b1;
    tick();

    // Decode error on the 3-channel bridge, then a valid access to its last channel
    cmd_b  = 16'd1;
    addr_b = 19'h6_0000;
    tick();
    check("dec_ack", 64'(ack_b), 64'd1);
    check("dec_nopulse", 64'(chrd_b | chwr_b), 64'd0);
    check("dec_rresp", 64'(rresp_b), 64'(RESP_DECERR));
    check("dec_bresp", 64'(bresp_b), 64'(RESP_DECERR));
    check("dec_errc", 64'(errc_b), 64'd1);
    cmd_b = 16'd0;
    tick();
    check("dec_ack_drop", 64'(ack_b), 64'd0);
    tick();
    cmd_b  = 16'd1;
    addr_b = 19'h4_0004;
    tick();
    check("b_rd_pulse", 64'(chrd_b), 64'd4);
    check("b_rd_chaddr", 64'(chaddr_b), 64'h4);
    tick();
    chack_b = 3'b100;
    chrdata_b[128 +: 64] = 64'h0123_4567_89AB_CDEF;
    tick();
    chack_b = '0;
    check("b_rd_ack", 64'(ack_b), 64'd1);
    check("b_rd_rdata", rdata_b, 64'h0123_4567_89AB_CDEF);
    check("b_rd_rresp", 64'(rresp_b), 64'(RESP_OKAY));
    check("b_rd_errc", 64'(errc_b), 64'd1);
    cmd_b = 16'd0;
    tick();

    // Normal traffic on the 4-channel bridge
    access("wr1", 1'b1, 19'h2_0010, 64'h1111_2222_3333_4444, 3, 1'b0, 64'hFFFF_0000_FFFF_0000, 1'b0);
    access("rd1", 1'b0, 19'h2_0010, 64'd0, 1, 1'b0, 64'h1111_2222_3333_4444, 1'b1);
    access("rd3", 1'b0, 19'h7_1234, 64'd0, 2, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    access("wr0", 1'b1, 19'h0_00FF, 64'hDEAD_BEEF_0000_0001, 1, 1'b0, 64'd0, 1'b0);

    // Timeout, then a late ack from the timed-out target must be ignored
    access("tmo", 1'b0, 19'h2_0020, 64'd0, -1, 1'b0, 64'd0, 1'b0);
    chack_a = 4'b0010;
    cherr_a = 4'b0010;
    tick();
    chack_a = '0;
    cherr_a = '0;
    tick();
    check("late_ack", 64'(ack_a), 64'd0);
    check("late_busy", 64'(busy_a), 64'd0);
    check("late_errc", 64'(errc_a), 64'(exp_err));
    access("rd_after_tmo", 1'b0, 19'h2_0020, 64'd0, 1, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0);

    // Target error and invalid command
    access("wr_err", 1'b1, 19'h4_0100, 64'h55, 2, 1'b1, 64'd0, 1'b0);
    invalid_cmd("inv");

    // Saturate the error counter
    for (int i = 0; i < 300; i++) begin
      cmd_a = 16'd3;
      tick();
      cmd_a = 16'd0;
      tick();
      if (exp_err < 255) exp_err++;
    end
    check("errc_sat", 64'(errc_a), 64'(exp_err));
    invalid_cmd("inv_sat");

    // Reset in the middle of WAIT
    cmd_a  = 16'd1;
    addr_a = 19'h2_0030;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 64'(ack_a), 64'd0);
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_errc", 64'(errc_a), 64'd0);
    check("mid_rst_pulses", 64'(chrd_a | chwr_a), 64'd0);
    exp_err = 0;
    cmd_a = 16'd0;
    tick();
    rst_n = 1'b1;
    tick();
    chack_a = 4'b0010;
    tick();
    chack_a = '0;
    tick();
    check("post_rst_ack", 64'(ack_a), 64'd0);
    check("post_rst_busy", 64'(busy_a), 64'd0);
    access("rd_post_rst", 1'b0, 19'h2_0030, 64'd0, 1, 1'b0, 64'h7777_8888_9999_AAAA, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
